// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns 6502-style CPU bus cycles into single-cycle
// read/write request pulses for the memory controller, stalls the CPU with
// cpu_rdy while an access is in flight, returns read data with a one-cycle
// cpu_rvalid pulse, and raises a sticky fault if the controller never finishes.
//
// Build option: define CPU_MEM_BRIDGE_POSTED_WRITE_EN to post writes. The
// CPU is then released the cycle after REQ while the write finishes in the
// background.
//
// Handshake: the CPU holds cpu_req (with cpu_we/cpu_addr/cpu_wdata) until it
// is accepted. Acceptance happens only on a rising edge where the bridge is
// IDLE with cpu_rdy=1. The memory side gets exactly one mem_read_en or
// mem_write_en pulse per access, then reports progress via mem_busy. The
// access completes on the first cycle mem_busy is low after having been high.
// A posted write pulses cpu_rdy for one cycle so the CPU can retire the
// write. Any request presented while that write is still outstanding waits
// for the write to reach DONE.
module cpu_mem_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

`ifdef CPU_MEM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // One-hot state encoding; 'state' is the observation point for checkers.
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    REQ  = 5'b00010,
    ACK  = 5'b00100,
    WAIT = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t             state;
  logic               op_we;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  // The timeout fires on the cycle whose increment would reach TIMEOUT.
  assign cnt_inc     = tmo_cnt + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // Bridge FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_we        <= 1'b0;
      tmo_cnt      <= '0;
      cpu_rdy      <= 1'b1;
      cpu_rdata    <= '0;
      cpu_rvalid   <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      fault        <= 1'b0;
    end else begin
      // Pulses default low; only the IDLE acceptance and completion raise them.
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      cpu_rvalid   <= 1'b0;
      case (state)
        IDLE: begin
          cpu_rdy <= 1'b1;
          if (cpu_req) begin
            mem_addr     <= cpu_addr;
            mem_wdata    <= cpu_wdata;
            op_we        <= cpu_we;
            mem_read_en  <= ~cpu_we;
            mem_write_en <= cpu_we;
            cpu_rdy      <= 1'b0;
            state        <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= '0;
          // A posted write frees the CPU for one cycle right after the pulse.
          cpu_rdy <= POSTED & op_we;
          state   <= ACK;
        end
        ACK: begin
          cpu_rdy <= 1'b0;
          tmo_cnt <= cnt_inc;
          if (timeout_hit) begin
            fault <= 1'b1;
            state <= DONE;
            if (!op_we) begin
              cpu_rdata  <= '0;
              cpu_rvalid <= 1'b1;
            end
          end else if (mem_busy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cpu_rdy <= 1'b0;
          tmo_cnt <= cnt_inc;
          if (!mem_busy) begin
            state <= DONE;
            if (!op_we) begin
              cpu_rdata  <= mem_rdata;
              cpu_rvalid <= 1'b1;
            end
          end else if (timeout_hit) begin
            fault <= 1'b1;
            state <= DONE;
            if (!op_we) begin
              cpu_rdata  <= '0;
              cpu_rvalid <= 1'b1;
            end
          end
        end
        DONE: begin
          cpu_rdy <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          cpu_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Testbench for cpu_mem_bridge: CPU driver tasks, a negedge memory-controller
// model, and a scoreboard of expected requests and read data.
module tb_cpu_mem_bridge;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;
`ifdef CPU_MEM_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rdy;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read_en;
  logic              mem_write_en;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_rdata;
  logic              fault;

  cpu_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .fault(fault)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0]        exp_q[$];      // expected read data, in order
  logic [ADDR_W+DATA_W:0]   exp_req_q[$];  // expected {we, addr, wdata}

  // memory model configuration (set by drivers before a request)
  int              m_busy_len = 1;
  bit              m_stuck    = 1'b0;
  logic [DATA_W-1:0] m_rdata_cfg = '0;
  // memory model state
  int              m_cnt  = 0;
  bit              m_hold = 1'b0;
  logic [DATA_W-1:0] m_rdata_lat = '0;
  logic            prev_en = 1'b0;
  logic            en_now;
  logic [ADDR_W+DATA_W:0] exp_req;
  logic [DATA_W-1:0] exp_d;

  // Memory controller model and output monitor, evaluated on the falling edge.
  // Busy is raised mid-REQ and held so the bridge samples it high for
  // m_busy_len rising edges; read data appears when busy drops.
  initial begin
    mem_busy  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_busy = 1'b0;
        m_cnt    = 0;
        m_hold   = 1'b0;
        prev_en  = 1'b0;
      end else begin
        if (m_cnt > 0 && !m_hold) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            mem_busy  = 1'b0;
            mem_rdata = m_rdata_lat;
          end
        end
        en_now = mem_read_en | mem_write_en;
        if (mem_read_en && mem_write_en) begin
          checks++;
          errors++;
          $display("FAIL en_overlap: read_en=%b write_en=%b, required not both", mem_read_en, mem_write_en);
        end
        if (en_now) begin
          checks++;
          if (prev_en) begin
            errors++;
            $display("FAIL en_pulse_width: enable high on consecutive cycles, required single pulse");
          end else if (exp_req_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: we=%b addr=%h, required no request", mem_write_en, mem_addr);
          end else begin
            exp_req = exp_req_q.pop_front();
            if ({mem_write_en, mem_addr, mem_wdata} !== exp_req) begin
              errors++;
              $display("FAIL req_fields: got %h required %h", {mem_write_en, mem_addr, mem_wdata}, exp_req);
            end
          end
          if (!prev_en) begin
            m_rdata_lat = m_rdata_cfg;
            m_hold      = m_stuck;
            mem_busy    = 1'b1;
            m_cnt       = m_busy_len + 1;
          end
        end
        prev_en = en_now;
        if (cpu_rvalid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: rdata=%h, required no rvalid", cpu_rdata);
          end else begin
            exp_d = exp_q.pop_front();
            if (cpu_rdata !== exp_d) begin
              errors++;
              $display("FAIL rdata: got %h required %h", cpu_rdata, exp_d);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one access, holding cpu_req until the enable pulse shows it was
  // accepted. lat counts cycles from acceptance to the first cpu_rdy=1
  // sample (5 for a 1-cycle busy); en_cyc is the cycle of the enable pulse.
  task automatic do_access(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input int nbusy,
                           input bit stuck, output int lat, output int en_cyc);
    logic [DATA_W-1:0] wd;
    int k;
    m_busy_len = nbusy;
    m_stuck    = stuck;
    if (we) begin
      wd = data;
    end else begin
      wd = DATA_W'($urandom_range(0, 255));
      m_rdata_cfg = data;
      exp_q.push_back(stuck ? '0 : data);
    end
    exp_req_q.push_back({we, addr, wd});
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_read_en || mem_write_en) && k < 200);
    cpu_req = 1'b0;
    en_cyc  = cyc;
    lat     = -1;
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: no enable pulse within 200 cycles for addr %h", addr);
      return;
    end
    lat = 1;
    while (!cpu_rdy && lat < 400) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_settle();
    repeat (8) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #12;
    checks++;
    if ({cpu_rdy, cpu_rvalid, cpu_rdata, fault} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_cpu: rdy/rvalid/rdata/fault=%b/%b/%h/%b required 1/0/00/0", cpu_rdy, cpu_rvalid, cpu_rdata, fault);
    end
    checks++;
    if ({mem_read_en, mem_write_en, mem_addr, mem_wdata} !== 26'h0) begin
      errors++;
      $display("FAIL reset_mem: ren/wen/addr/wdata=%b/%b/%h/%h required zeros", mem_read_en, mem_write_en, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat, ec;
    do_access(1'b0, 16'h1234, 8'hA5, 3, 1'b0, lat, ec);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL read_latency: got %0d required 7", lat);
    end
    wait_settle();
  endtask

  task automatic test_write();
    int lat, ec, exp_lat;
    exp_lat = POSTED ? 2 : 5;
    do_access(1'b1, 16'hFFFC, 8'h3C, 1, 1'b0, lat, ec);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL write_latency: got %0d required %0d", lat, exp_lat);
    end
    wait_settle();
  endtask

  task automatic test_back_to_back();
    int k, c1, c2;
    m_busy_len = 1; m_stuck = 1'b0; m_rdata_cfg = 8'h5E;
    exp_q.push_back(8'h5E);
    exp_req_q.push_back({1'b0, 16'h0000, 8'h00});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read_en && k < 50);
    c1 = cyc;
    // Request stays asserted; the CPU now presents its next (write) cycle.
    exp_req_q.push_back({1'b1, 16'h0001, 8'h77});
    cpu_we = 1'b1; cpu_addr = 16'h0001; cpu_wdata = 8'h77;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_write_en && k < 50);
    c2 = cyc;
    cpu_req = 1'b0;
    checks++;
    if (c2 - c1 !== 5) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between pulses required 5", c2 - c1);
    end
    k = 0;
    while (!cpu_rdy && k < 50) begin @(negedge clk); k++; end
    wait_settle();
  endtask

  task automatic test_random();
    int lat, ec, nb, exp_lat;
    logic we;
    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      do_access(we, ADDR_W'($urandom_range(0, 65535)), DATA_W'($urandom_range(0, 255)), nb, 1'b0, lat, ec);
      exp_lat = (we && POSTED) ? 2 : nb + 4;
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL rand_latency[%0d]: we=%b busy=%0d got %0d required %0d", i, we, nb, lat, exp_lat);
      end
    end
    wait_settle();
  endtask

  task automatic test_timeout();
    int lat, ec;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_pre: got %b required 0", fault);
    end
    do_access(1'b0, 16'h2222, 8'hEE, 1, 1'b1, lat, ec);
    checks++;
    if (lat !== TIMEOUT + 3) begin
      errors++;
      $display("FAIL timeout_latency: got %0d required %0d", lat, TIMEOUT + 3);
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_set: got %b required 1", fault);
    end
    // Release the stuck controller, then confirm service continues.
    m_hold = 1'b0; m_cnt = 1;
    repeat (2) @(negedge clk);
    do_access(1'b0, 16'h3333, 8'h5A, 1, 1'b0, lat, ec);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL post_timeout_latency: got %0d required 5", lat);
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: got %b required 1", fault);
    end
    wait_settle();
  endtask

  task automatic test_reset_mid();
    int k, lat, ec;
    logic [DATA_W-1:0] dropped;
    m_busy_len = 6; m_stuck = 1'b0; m_rdata_cfg = 8'h99;
    exp_q.push_back(8'h99);
    exp_req_q.push_back({1'b0, 16'h4321, 8'h00});
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4321; cpu_wdata = 8'h00;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_read_en && k < 50);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);   // now mid-WAIT
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cpu_rdy, cpu_rvalid, cpu_rdata, fault} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midreset_cpu: rdy/rvalid/rdata/fault=%b/%b/%h/%b required 1/0/00/0", cpu_rdy, cpu_rvalid, cpu_rdata, fault);
    end
    checks++;
    if ({mem_read_en, mem_write_en, mem_addr, mem_wdata} !== 26'h0) begin
      errors++;
      $display("FAIL midreset_mem: ren/wen/addr/wdata=%b/%b/%h/%h required zeros", mem_read_en, mem_write_en, mem_addr, mem_wdata);
    end
    dropped = exp_q.pop_back();   // aborted read never responds
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_access(1'b0, 16'h0BEE, 8'hC3, 2, 1'b0, lat, ec);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL after_reset_latency: got %0d required 6 (dropped %h)", lat, dropped);
    end
    wait_settle();
  endtask

`ifdef CPU_MEM_BRIDGE_POSTED_WRITE_EN
  task automatic test_posted();
    int lat_w, lat_r, ec_w, ec_r;
    do_access(1'b1, 16'h0010, 8'h11, 3, 1'b0, lat_w, ec_w);
    do_access(1'b0, 16'h0020, 8'h99, 1, 1'b0, lat_r, ec_r);
    checks++;
    if (lat_w !== 2) begin
      errors++;
      $display("FAIL posted_write_latency: got %0d required 2", lat_w);
    end
    checks++;
    if (ec_r - ec_w !== 7) begin
      errors++;
      $display("FAIL posted_read_wait: read pulse %0d cycles after write, required 7", ec_r - ec_w);
    end
    checks++;
    if (lat_r !== 5) begin
      errors++;
      $display("FAIL posted_read_latency: got %0d required 5", lat_r);
    end
    wait_settle();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef CPU_MEM_BRIDGE_POSTED_WRITE_EN
    test_posted();
`endif
    checks++;
    if (exp_q.size() != 0 || exp_req_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads and %0d requests outstanding, required 0", exp_q.size(), exp_req_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
